bram_burst_reader: RTL and testbench
====================================

BRAM_BURST_READER -- requirements
Module: bram_burst_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output buffer depth in 512-bit words; SHALL be >= READ_LATENCY+1.
REQ-002 Parameter READ_LATENCY, default 2, BRAM read latency in cycles; SHALL take its default from the shared package.
REQ-003 Port clk, input, 1, single clock for all logic.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port start, input, 1, one-cycle pulse that launches a burst.
REQ-006 Port address_start, input, 17, byte address of the first word; sampled on an accepted start.
REQ-007 Port length, input, 12, number of 512-bit words to read; sampled on an accepted start.
REQ-008 Port m_en, output, 1, BRAM port chip enable; one read per asserted cycle.
REQ-009 Port m_addr, output, 17, BRAM byte address.
REQ-010 Port m_dout, input, 512, BRAM read data; valid READ_LATENCY cycles after m_en.
REQ-011 Port out_data, output, 512, head word of the FIFO.
REQ-012 Port out_valid, output, 1, out_data is valid.
REQ-013 Port out_ready, input, 1, downstream accept; a transfer occurs when out_valid && out_ready.
REQ-014 Port busy, output, 1, high in READ or DRAIN.
REQ-015 Port done, output, 1, level-high completion interrupt.

Function
REQ-016 States: IDLE, READ, DRAIN, DONE.
REQ-017 start in IDLE or DONE SHALL load address/length, clear done, and go to READ; if length==0, SHALL go directly to DONE instead.
REQ-018 start in READ or DRAIN SHALL be ignored.
REQ-019 In READ, m_en SHALL be high in a cycle iff words issued < length and (FIFO occupancy + reads in flight) < FIFO_DEPTH.
REQ-020 The first m_en SHALL occur the cycle after an accepted start, with m_addr = address_start.
REQ-021 Each issued read SHALL advance m_addr by 64, wrapping modulo 2^17.
REQ-022 A READ_LATENCY-deep valid shift register SHALL track in-flight reads; m_dout SHALL be pushed into the FIFO in the cycle its valid bit emerges.
REQ-023 A word read on m_en at cycle t SHALL appear on out_data with out_valid at cycle t+READ_LATENCY+1 if the FIFO was empty.
REQ-024 Words SHALL be delivered in address order with no loss or duplication; the FIFO SHALL never overflow under any out_ready pattern.
REQ-025 The FIFO SHALL support simultaneous push and pop when full or empty; when empty, a word pushed that cycle is not popped until the next cycle.
REQ-026 READ -> DRAIN when the last read is issued; DRAIN -> DONE when nothing is in flight and the FIFO is empty.
REQ-027 done SHALL be high exactly while in DONE and remain high until the next accepted start or reset.
REQ-028 m_en SHALL be low outside READ.

Reset
REQ-029 On rst, state = IDLE; m_en, out_valid, busy, done = 0; m_addr = 0; the FIFO and the in-flight pipeline SHALL be cleared.
REQ-030 rst mid-burst SHALL discard all in-flight and buffered data; no word from the aborted burst SHALL appear after reset.

Configuration
REQ-031 Macro BRAM_READER_PERF_EN: when defined, add output stall_cycles (32 bits), counting READ/DRAIN cycles with out_valid && !out_ready; cleared on accepted start and on rst; saturates at all-ones.
REQ-032 When BRAM_READER_PERF_EN is undefined, the stall_cycles port and its counter SHALL be absent, with no other behaviour change.

Structure
REQ-033 Package bnn_pkg SHALL hold BRAM_DATA_W=512, BRAM_ADDR_W=17, BRAM_READ_LATENCY=2, WORD_BYTES=64, and the state enum typedef.
REQ-034 The FIFO SHALL be a sub-module bram_rd_fifo (parameterised width/depth, with occupancy count); all other logic is top-level.

Verification
REQ-035 start, address 0x00040, length 3, out_ready=1 -> m_en high cycles 1-3 at addresses 0x00040/0x00080/0x000C0; data out cycles 4-6; done from cycle 7.
REQ-036 length 10, out_ready=0 -> exactly 4 reads issued, then m_en stays low; raise out_ready -> all 10 words delivered in order; done asserted.
REQ-037 address 0x1FFC0, length 2 -> second read at m_addr 0x00000.
REQ-038 length 0 -> no m_en; done the cycle after start; a start during READ is ignored (length unchanged).
REQ-039 rst asserted with 2 reads in flight -> out_valid low the next cycle; no stale words after a new start of length 1.
REQ-040 Random out_ready, 50% duty, length 100 -> scoreboard matches the BRAM model; with BRAM_READER_PERF_EN, stall_cycles equals the count of cycles with out_valid && !out_ready.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared constants and types for the BRAM burst reader.
//   BRAM_DATA_W       : width of one BRAM word in bits
//   BRAM_ADDR_W       : width of the BRAM byte address
//   BRAM_READ_LATENCY : cycles from chip enable to valid read data
//   WORD_BYTES        : byte stride between consecutive BRAM words
//   rd_state_t        : burst reader control states
package bnn_pkg;

  localparam int BRAM_DATA_W       = 512;
  localparam int BRAM_ADDR_W       = 17;
  localparam int BRAM_READ_LATENCY = 2;
  localparam int WORD_BYTES        = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  // Address of the next word; wraps naturally at the top of the address space.
  function automatic logic [BRAM_ADDR_W-1:0] next_word_addr(input logic [BRAM_ADDR_W-1:0] addr);
    return addr + BRAM_ADDR_W'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO buffering BRAM read data for the downstream consumer.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (clears pointers/count)
//   push      : write push_data this cycle (dropped only if full with no pop)
//   push_data : word to write
//   pop       : remove the head word (ignored while empty)
//   pop_data  : head word, valid whenever empty is low
//   count     : current occupancy in words
//   empty     : FIFO holds no words
// A push into an empty FIFO is only visible (and poppable) from the next cycle.
module bram_rd_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO can still accept a word in the same cycle it releases one.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bram_burst_reader.sv
// Reads a burst of consecutive 512-bit words from a BRAM port and streams them
// out through a valid/ready interface, throttling reads so the output buffer
// can never overflow.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   start          : one-cycle pulse launching a burst (accepted in IDLE/DONE)
//   address_start  : byte address of the first word
//   length         : number of words in the burst (0 finishes immediately)
//   m_en, m_addr   : BRAM chip enable and byte address, one read per m_en
//   m_dout         : BRAM read data, valid READ_LATENCY cycles after m_en
//   out_data       : head word of the output buffer
//   out_valid      : out_data is valid
//   out_ready      : downstream accepts out_data this cycle
//   busy           : burst in progress (READ or DRAIN)
//   done           : level completion flag, held until the next accepted start
//   stall_cycles   : (only with BRAM_READER_PERF_EN) busy cycles in which
//                    out_valid was high and out_ready low; saturating
// Optional feature macro: BRAM_READER_PERF_EN adds the stall_cycles counter.
// FIFO_DEPTH must be at least READ_LATENCY+1 to keep reads streaming.
module bram_burst_reader
  import bnn_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = BRAM_READ_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BRAM_ADDR_W-1:0] address_start,
  input  logic [11:0]            length,
  output logic                   m_en,
  output logic [BRAM_ADDR_W-1:0] m_addr,
  input  logic [BRAM_DATA_W-1:0] m_dout,
  output logic [BRAM_DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
`ifdef BRAM_READER_PERF_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  rd_state_t              state_q;
  rd_state_t              state_d;
  logic [11:0]            len_q;
  logic [11:0]            issued_q;
  logic [READ_LATENCY-1:0] vld_sr;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   start_ok;
  logic                   last_issue;
  logic                   has_room;
  logic                   drain_empty;
  int                     inflight;

  assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
  assign fifo_push = vld_sr[READ_LATENCY-1];
  assign fifo_pop  = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign last_issue = m_en && (issued_q == (len_q - 12'd1));

  // Reads already issued but not yet in the FIFO must be counted against its
  // space; the word pushed this cycle is still counted here, not in the FIFO.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + int'(vld_sr[i]);
    end
    has_room = (int'(fifo_count) + inflight) < FIFO_DEPTH;
  end

  // The burst is finished once nothing is in flight and the FIFO will be
  // empty after this cycle's pop, so done rises right after the last transfer.
  assign drain_empty = (vld_sr == '0) &&
                       ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero-length burst jumps straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d = (length == 12'd0) ? DONE : READ;
        end
      end
      READ: begin
        if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_empty) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; reads are issued only while there is guaranteed buffer space.
  always_comb begin
    m_en = (state_q == READ) && (issued_q < len_q) && has_room;
    busy = (state_q == READ) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  // Burst address and word counters, loaded on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_addr   <= '0;
      len_q    <= '0;
      issued_q <= '0;
    end else if (start_ok) begin
      m_addr   <= address_start;
      len_q    <= length;
      issued_q <= '0;
    end else if (m_en) begin
      m_addr   <= next_word_addr(m_addr);
      issued_q <= issued_q + 12'd1;
    end
  end

  // Valid shift register tracking reads in flight through the BRAM pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= m_en;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  bram_rd_fifo #(
    .WIDTH (BRAM_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (m_dout),
    .pop       (fifo_pop),
    .pop_data  (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

`ifdef BRAM_READER_PERF_EN
  // Back-pressure counter: busy cycles where a word waited on the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (start_ok) begin
      stall_cycles <= '0;
    end else if (busy && out_valid && !out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_burst_reader.sv
// Testbench for bram_burst_reader: BRAM model with READ_LATENCY pipeline,
// scoreboard queue filled at stimulus time and drained by an output monitor.
module tb_bram_burst_reader;
  import bnn_pkg::*;

  localparam int RL = BRAM_READ_LATENCY;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [16:0]  address_start;
  logic [11:0]  length;
  logic         m_en;
  logic [16:0]  m_addr;
  logic [511:0] m_dout;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;
`ifdef BRAM_READER_PERF_EN
  logic [31:0]  stall_cycles;
`endif

  int           n_checks = 0;
  int           n_fail = 0;
  int           men_cnt;
  int           stall_ref;
  logic [511:0] exp_q[$];
  logic [511:0] exp_word;
  logic [511:0] rd_pipe [RL];

  always #5 clk = ~clk;

  bram_burst_reader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .address_start (address_start),
    .length        (length),
    .m_en          (m_en),
    .m_addr        (m_addr),
    .m_dout        (m_dout),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done)
`ifdef BRAM_READER_PERF_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  // Content of the BRAM word at a byte address: address tagged into each lane.
  function automatic logic [511:0] bramWord(input logic [16:0] a);
    logic [511:0] w;
    for (int i = 0; i < 8; i++) begin
      w[i*64 +: 64] = {32'hC0DE_0000 | 32'(i), 15'd0, a};
    end
    return w;
  endfunction

  // BRAM model: data appears RL cycles after m_en; junk when not enabled.
  always @(posedge clk) begin
    rd_pipe[0] <= m_en ? bramWord(m_addr) : {16{32'hDEADBEEF}};
    for (int i = 1; i < RL; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign m_dout = rd_pipe[RL-1];

  // Monitor: every transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_word: got %h, expected no transfer", out_data);
      end else begin
        exp_word = exp_q.pop_front();
        if (out_data !== exp_word) begin
          n_fail++;
          $display("[TB] FAIL data: got %h, expected %h", out_data, exp_word);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pulse start for one cycle; queue the expected words if it should be accepted.
  task automatic applyStimulus(input logic [16:0] a, input logic [11:0] len, input bit accept);
    logic [16:0] ak;
    @(posedge clk);
    #1;
    start         = 1'b1;
    address_start = a;
    length        = len;
    if (accept) begin
      for (int k = 0; k < int'(len); k++) begin
        ak = a + 17'(k * 64);
        exp_q.push_back(bramWord(ak));
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      men_cnt += int'(m_en);
    end
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      men_cnt += int'(m_en);
      if (done === 1'b1) break;
    end
    checkOutput(name, 32'(done), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    address_start = '0;
    length        = '0;
    out_ready     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_m_en", 32'(m_en), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_m_addr", 32'(m_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic three-word burst with cycle-exact timing.
    out_ready = 1'b1;
    applyStimulus(17'h00040, 12'd3, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t1_m_en_c%0d", c), 32'(m_en), 32'(c <= 3));
      if (c <= 3) checkOutput($sformatf("t1_m_addr_c%0d", c), 32'(m_addr), 32'h40 * c);
      checkOutput($sformatf("t1_out_valid_c%0d", c), 32'(out_valid), 32'(c >= 4 && c <= 6));
      checkOutput($sformatf("t1_done_c%0d", c), 32'(done), 32'(c >= 7));
    end
    checkOutput("t1_leftover", 32'(exp_q.size()), 32'd0);

    // Back-pressure: only FIFO_DEPTH reads may be outstanding.
    out_ready = 1'b0;
    men_cnt = 0;
    applyStimulus(17'h01000, 12'd10, 1'b1);
    run_cycles(20);
    checkOutput("t2_reads_stalled", 32'(men_cnt), 32'd4);
    checkOutput("t2_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done(100, "t2_done");
    checkOutput("t2_reads_total", 32'(men_cnt), 32'd10);
    checkOutput("t2_leftover", 32'(exp_q.size()), 32'd0);

    // Address wrap at the top of the BRAM.
    applyStimulus(17'h1FFC0, 12'd2, 1'b1);
    @(negedge clk);
    checkOutput("t3_m_en_1", 32'(m_en), 32'd1);
    checkOutput("t3_m_addr_1", 32'(m_addr), 32'h1FFC0);
    @(negedge clk);
    checkOutput("t3_m_en_2", 32'(m_en), 32'd1);
    checkOutput("t3_m_addr_2", 32'(m_addr), 32'h00000);
    wait_done(50, "t3_done");
    checkOutput("t3_leftover", 32'(exp_q.size()), 32'd0);

    // Zero-length burst completes immediately.
    applyStimulus(17'h00100, 12'd0, 1'b1);
    @(negedge clk);
    checkOutput("t4_m_en", 32'(m_en), 32'd0);
    checkOutput("t4_done", 32'(done), 32'd1);
    checkOutput("t4_busy", 32'(busy), 32'd0);

    // Start during a burst is ignored.
    out_ready = 1'b0;
    men_cnt = 0;
    applyStimulus(17'h03000, 12'd10, 1'b1);
    run_cycles(8);
    applyStimulus(17'h05000, 12'd3, 1'b0);
    checkOutput("t5_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done(100, "t5_done");
    checkOutput("t5_reads_total", 32'(men_cnt), 32'd10);
    checkOutput("t5_leftover", 32'(exp_q.size()), 32'd0);

    // Reset mid-burst discards all in-flight and buffered words.
    applyStimulus(17'h08000, 12'd8, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_m_en", 32'(m_en), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_m_addr", 32'(m_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_cycles(5);
    applyStimulus(17'h0A000, 12'd1, 1'b1);
    wait_done(50, "t6_done");
    checkOutput("t6_leftover", 32'(exp_q.size()), 32'd0);

    // Long burst with random consumer back-pressure.
    stall_ref = 0;
    applyStimulus(17'h02000, 12'd100, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (busy && out_valid && !out_ready) stall_ref++;
      if (done === 1'b1) break;
    end
    checkOutput("t7_done", 32'(done), 32'd1);
    checkOutput("t7_leftover", 32'(exp_q.size()), 32'd0);
`ifdef BRAM_READER_PERF_EN
    checkOutput("t7_stall_cycles", stall_cycles, 32'(stall_ref));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
